// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: latches UART bytes for the segment decoder and time-multiplexes its three
// codes onto one active-low segment bus. Optional macro RX_ACTIVITY_DP_EN adds an activity dot (dp).
module disp_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int HOLD_FRAMES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] dec_in,
  output logic       dec_bandera,
  input  logic [6:0] msg_seg,
  input  logic [6:0] el_seg,
  input  logic [6:0] yo_seg,
  output logic [6:0] seg,
  output logic [3:0] an
`ifdef RX_ACTIVITY_DP_EN
  ,
  output logic       dp
`endif
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = (HOLD_FRAMES > 0) ? HW'(HOLD_FRAMES - 1) : '0;

  typedef enum logic [1:0] {S_MSG, S_EL, S_YO, S_OFF} slot_t;

  slot_t          slot_q, slot_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [7:0]     dec_in_d;
  logic           band_d;
  logic [6:0]     seg_d;
  logic [3:0]     an_d;
  logic           cnt_last, guard, frame_end;

  assign cnt_last  = (cnt_q == CNT_LAST);
  assign guard     = (cnt_q == '0);
  assign frame_end = (slot_q == S_OFF) && cnt_last;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= S_MSG;
      cnt_q       <= '0;
      hold_q      <= '0;
      dec_in      <= 8'h00;
      dec_bandera <= 1'b0;
      seg         <= 7'b1111111;
      an          <= 4'b1111;
    end else begin
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      dec_in      <= dec_in_d;
      dec_bandera <= band_d;
      seg         <= seg_d;
      an          <= an_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    slot_d   = slot_q;
    cnt_d    = cnt_q + 1'b1;
    an_d     = 4'b1111;
    seg_d    = 7'b1111111;
    dec_in_d = dec_in;
    band_d   = dec_bandera;
    hold_d   = hold_q;

    if (cnt_last) begin
      cnt_d = '0;
      unique case (slot_q)
        S_MSG: slot_d = S_EL;
        S_EL:  slot_d = S_YO;
        S_YO:  slot_d = S_OFF;
        S_OFF: slot_d = S_MSG;
      endcase
    end

    // The guard cycle keeps anodes dark but already presents the slot's code on seg.
    unique case (slot_q)
      S_MSG: begin seg_d = msg_seg; if (!guard) an_d = 4'b1110; end
      S_EL:  begin seg_d = el_seg;  if (!guard) an_d = 4'b1101; end
      S_YO:  begin seg_d = yo_seg;  if (!guard) an_d = 4'b1011; end
      S_OFF: begin seg_d = 7'b1111111; an_d = 4'b1111; end
    endcase

    // A new byte wins over an expiry landing in the same cycle.
    if (rx_done) begin
      dec_in_d = rx_data;
      band_d   = 1'b1;
      hold_d   = '0;
    end else if (frame_end && dec_bandera && (HOLD_FRAMES != 0)) begin
      if (hold_q == HOLD_LAST) begin
        band_d = 1'b0;
        hold_d = '0;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

`ifdef RX_ACTIVITY_DP_EN
  logic [3:0] act_q, act_d;
  logic       dp_d;

  // act_q counts the frame ends left in the activity window; dp follows the msg anode.
  always_comb begin
    act_d = act_q;
    if (rx_done)
      act_d = 4'd8;
    else if (frame_end && (act_q != 4'd0))
      act_d = act_q - 4'd1;
    dp_d = ~((act_q != 4'd0) && (an_d == 4'b1110));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= 4'd0;
      dp    <= 1'b1;
    end else begin
      act_q <= act_d;
      dp    <= dp_d;
    end
  end
`endif

endmodule
